clock_monitor: RTL and testbench

Measures the half-period of a slow, free-running square wave (e.g. the output of the board's clock divider) in units of the fast system clock. It declares lock once a run of consecutive measurements matches the expected value, and flags loss of the input. It sits in the fast `clk_in` domain as the checking end of a divided clock: it confirms that the divided rate is correct and still toggling.

---
 rtl/clock_monitor.sv | 157 +++++++++++++++
 tb/tb_clock_monitor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// Half-period monitor for a slow square wave sampled in the clk_in domain.
// Measures toggle-to-toggle intervals, declares lock after a run of matches and flags loss of toggling.
module clock_monitor #(
    parameter int CNT_W       = 25,
    parameter int EXPECT_HALF = 5,
    parameter int TOL         = 0,
    parameter int LOCK_N      = 4,
    parameter int TIMEOUT     = 20
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout_err,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_e;

    localparam int                      MW     = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0]        ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0]        EXP_C  = CNT_W'(EXPECT_HALF);
    localparam logic [CNT_W-1:0]        TO_C   = CNT_W'(TIMEOUT);
    localparam logic signed [CNT_W:0]   TOL_C  = (CNT_W + 1)'(TOL);
    localparam logic [MW-1:0]           LOCK_C = MW'(LOCK_N);

    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;
    logic [MW-1:0]    match_q, match_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             pv_q, pv_d;
    logic             locked_q, locked_d;
    logic             terr_q, terr_d;

    logic                    tgl;
    logic                    cnt_sat;
    logic [CNT_W-1:0]        meas;
    logic signed [CNT_W:0]   diff;
    logic signed [CNT_W:0]   abs_diff;
    logic                    is_match;
    logic                    timeout_hit;
    logic [MW-1:0]           match_inc;

    assign tgl      = s2_q ^ s3_q;
    assign cnt_sat  = &cnt_q;
    assign meas     = cnt_sat ? cnt_q : cnt_q + ONE_C;
    assign diff     = $signed({1'b0, meas}) - $signed({1'b0, EXP_C});
    assign abs_diff = diff[CNT_W] ? -diff : diff;
    assign is_match = (abs_diff <= TOL_C);
    // An edge in the same cycle as the timeout threshold wins.
    assign timeout_hit = (state_q != IDLE) && !tgl && (meas == TO_C);
    assign match_inc   = match_q + MW'(1);

    assign cnt_d = tgl ? '0 : meas;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            s3_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= sig_in;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            match_q  <= '0;
            half_q   <= '0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            half_q   <= half_d;
            pv_q     <= pv_d;
            locked_q <= locked_d;
            terr_q   <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        unique case (state_q)
            IDLE: begin
                if (tgl) begin
                    state_d = ACQ;
                    match_d = '0;
                end
            end
            ACQ: begin
                if (tgl) begin
                    if (is_match) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_C) state_d = LOCK;
                    end else begin
                        match_d = '0;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    match_d = '0;
                end
            end
            LOCK: begin
                if (tgl) begin
                    if (!is_match) begin
                        state_d = ACQ;
                        match_d = '0;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    match_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                match_d = '0;
            end
        endcase
    end

    // The first toggle out of IDLE is only a reference, so it yields no measurement.
    always_comb begin
        pv_d     = tgl && (state_q != IDLE);
        half_d   = pv_d ? meas : half_q;
        locked_d = (state_d == LOCK);
        terr_d   = terr_q;
        if (tgl) begin
            terr_d = 1'b0;
        end else if (timeout_hit) begin
            terr_d = 1'b1;
        end
    end

    assign half_period  = half_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign timeout_err  = terr_q;
    assign state_o      = state_q;
    assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: lock, mismatch, timeout, tolerance, async reset, counter saturation.
module tb_clock_monitor;

    logic clk = 1'b0;
    logic reset_n;
    logic sig_in;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [24:0] hp0, cn0;
    logic        pv0, lk0, to0;
    logic [1:0]  st0;
    logic [24:0] hp2, cn2;
    logic        pv2, lk2, to2;
    logic [1:0]  st2;
    logic [3:0]  hps, cns;
    logic        pvs, lks, tos;
    logic [1:0]  sts;

    clock_monitor #(.CNT_W(25), .EXPECT_HALF(5), .TOL(0), .LOCK_N(4), .TIMEOUT(20)) dut0 (
        .clk_in(clk), .reset_n(reset_n), .sig_in(sig_in),
        .half_period(hp0), .period_valid(pv0), .locked(lk0), .timeout_err(to0),
        .state_o(st0), .cnt_o(cn0)
    );

    clock_monitor #(.CNT_W(25), .EXPECT_HALF(5), .TOL(2), .LOCK_N(4), .TIMEOUT(20)) dut2 (
        .clk_in(clk), .reset_n(reset_n), .sig_in(sig_in),
        .half_period(hp2), .period_valid(pv2), .locked(lk2), .timeout_err(to2),
        .state_o(st2), .cnt_o(cn2)
    );

    clock_monitor #(.CNT_W(4), .EXPECT_HALF(5), .TOL(0), .LOCK_N(4), .TIMEOUT(12)) duts (
        .clk_in(clk), .reset_n(reset_n), .sig_in(sig_in),
        .half_period(hps), .period_valid(pvs), .locked(lks), .timeout_err(tos),
        .state_o(sts), .cnt_o(cns)
    );

    // Scoreboard entries are {locked, half_period} expected with each period_valid pulse.
    logic [25:0] exp_q[$];
    logic [25:0] exp2_q[$];
    logic [25:0] e0, e2;
    logic        mon2_en = 1'b0;
    int          pvs_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pv0) begin
            if (exp_q.size() == 0) begin
                check("pv0_unexpected", 32'(1), 32'(0));
            end else begin
                e0 = exp_q.pop_front();
                check("pv0_half", 32'(hp0), 32'(e0[24:0]));
                check("pv0_lock", 32'(lk0), 32'(e0[25]));
            end
        end
        if (mon2_en && pv2) begin
            if (exp2_q.size() == 0) begin
                check("pv2_unexpected", 32'(1), 32'(0));
            end else begin
                e2 = exp2_q.pop_front();
                check("pv2_half", 32'(hp2), 32'(e2[24:0]));
                check("pv2_lock", 32'(lk2), 32'(e2[25]));
            end
        end
        if (pvs) pvs_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle();
        sig_in = ~sig_in;
    endtask

    task automatic gap_toggle(input int n);
        repeat (n) tick();
        toggle();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sig_in  = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic push0(input logic lk, input int hp);
        exp_q.push_back({lk, 25'(hp)});
    endtask

    task automatic push2(input logic lk, input int hp);
        exp2_q.push_back({lk, 25'(hp)});
    endtask

    initial begin
        reset_n = 1'b0;
        sig_in  = 1'b0;
        repeat (2) tick();
        check("rst_half", 32'(hp0), 32'(0));
        check("rst_pv", 32'(pv0), 32'(0));
        check("rst_lock", 32'(lk0), 32'(0));
        check("rst_to", 32'(to0), 32'(0));
        check("rst_state", 32'(st0), 32'(0));
        check("rst_cnt", 32'(cn0), 32'(0));
        reset_n = 1'b1;

        // Steady 5-cycle toggling: reference toggle, then lock on the 4th measurement.
        repeat (3) tick();
        toggle();
        for (int i = 0; i < 6; i++) begin
            push0(i >= 3, 5);
            gap_toggle(5);
        end
        repeat (4) tick();
        check("s1_drain", 32'(exp_q.size()), 32'(0));
        check("s1_locked", 32'(lk0), 32'(1));
        push0(1'b1, 5);
        gap_toggle(1);

        // One 6-cycle interval drops lock, four good intervals regain it.
        push0(1'b0, 6);
        gap_toggle(6);
        for (int i = 0; i < 4; i++) begin
            push0(i == 3, 5);
            gap_toggle(5);
        end

        // Input stops: timeout 20 cycles after the last period_valid.
        repeat (22) tick();
        check("s3_drain", 32'(exp_q.size()), 32'(0));
        check("s3_pre_to", 32'(to0), 32'(0));
        check("s3_pre_lock", 32'(lk0), 32'(1));
        tick();
        check("s3_to", 32'(to0), 32'(1));
        check("s3_unlock", 32'(lk0), 32'(0));
        check("s3_idle", 32'(st0), 32'(0));
        check("s3_hold_half", 32'(hp0), 32'(5));
        toggle();
        repeat (2) tick();
        check("s3_to_held", 32'(to0), 32'(1));
        tick();
        check("s3_to_clr", 32'(to0), 32'(0));
        check("s3_acq", 32'(st0), 32'(1));
        push0(1'b0, 5);
        gap_toggle(2);
        repeat (4) tick();
        check("s3_drain2", 32'(exp_q.size()), 32'(0));

        // Alternating 5/7 intervals: TOL=0 never locks, TOL=2 locks on the 4th.
        do_reset();
        mon2_en = 1'b1;
        repeat (2) tick();
        toggle();
        for (int i = 0; i < 8; i++) begin
            push0(1'b0, (i % 2 == 1) ? 7 : 5);
            push2(i >= 3, (i % 2 == 1) ? 7 : 5);
            gap_toggle((i % 2 == 1) ? 7 : 5);
        end
        repeat (4) tick();
        check("s4_drain0", 32'(exp_q.size()), 32'(0));
        check("s4_drain2", 32'(exp2_q.size()), 32'(0));
        check("s4_tol0_lock", 32'(lk0), 32'(0));
        check("s4_tol2_lock", 32'(lk2), 32'(1));
        mon2_en = 1'b0;

        // Async reset mid-interval while locked, then the lock sequence repeats.
        do_reset();
        repeat (2) tick();
        toggle();
        for (int i = 0; i < 4; i++) begin
            push0(i == 3, 5);
            gap_toggle(5);
        end
        repeat (4) tick();
        check("s5_pre_lock", 32'(lk0), 32'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("s5_rst_half", 32'(hp0), 32'(0));
        check("s5_rst_pv", 32'(pv0), 32'(0));
        check("s5_rst_lock", 32'(lk0), 32'(0));
        check("s5_rst_to", 32'(to0), 32'(0));
        check("s5_rst_state", 32'(st0), 32'(0));
        check("s5_rst_cnt", 32'(cn0), 32'(0));
        sig_in = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        toggle();
        for (int i = 0; i < 4; i++) begin
            push0(i == 3, 5);
            gap_toggle(5);
        end
        repeat (4) tick();
        check("s5_drain", 32'(exp_q.size()), 32'(0));
        check("s5_relock", 32'(lk0), 32'(1));

        // Constant input from reset: 4-bit counter saturates, IDLE never times out.
        do_reset();
        pvs_cnt = 0;
        repeat (40) tick();
        check("s6_sat", 32'(cns), 32'(15));
        check("s6_to", 32'(tos), 32'(0));
        check("s6_idle", 32'(sts), 32'(0));
        check("s6_no_pv", 32'(pvs_cnt), 32'(0));
        check("s6_cnt0", 32'(cn0), 32'(40));
        check("s6_to0", 32'(to0), 32'(0));
        toggle();
        repeat (3) tick();
        check("s6_acq", 32'(sts), 32'(1));
        check("s6_ref_no_pv", 32'(pvs_cnt), 32'(0));
        check("s6_cnt_clr", 32'(cns), 32'(0));
        push0(1'b0, 5);
        gap_toggle(2);
        repeat (4) tick();
        check("s6_one_pv", 32'(pvs_cnt), 32'(1));
        check("s6_half", 32'(hps), 32'(5));
        check("s6_drain", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
